// File: rtl/jtag_host_controller.sv
// Host-side IEEE 1149.1 driver: runs TAP reset, IR scan and DR scan commands
// (up to 32 bits, LSB first) and returns the TDO bits captured during the shift.
module jtag_host_controller #(
    parameter int CLOCK_DIVIDER = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [4:0]  cmd_length,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        jtag_tck,
    output logic        jtag_tms,
    output logic        jtag_tdi,
    input  logic        jtag_tdo,
    output logic        busy
);

    localparam logic [7:0] DIV_RELOAD = 8'(CLOCK_DIVIDER - 1);
    localparam logic [5:0] RESET_PAT  = 6'b011111;

    typedef enum logic [2:0] {
        S_RESET_SEQ,
        S_IDLE,
        S_PREAMBLE,
        S_SHIFT,
        S_POSTAMBLE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_div;
    logic        r_tck;
    logic        r_tms;
    logic        r_tdi;
    logic        r_cmd_ready;
    logic        r_busy;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_is_scan;
    logic [4:0]  r_len;
    logic [4:0]  r_shift_cnt;
    logic [31:0] r_data;
    logic [31:0] r_cap;
    logic [5:0]  r_pat;
    logic [2:0]  r_pre_left;
    logic        r_post_last;

    logic        w_active;
    logic        w_fall;
    logic [5:0]  w_pat;
    logic [2:0]  w_pre_left;
    logic        w_is_scan;

    assign w_active = (r_state == S_RESET_SEQ) || (r_state == S_PREAMBLE) ||
                      (r_state == S_SHIFT)     || (r_state == S_POSTAMBLE);
    assign w_fall   = w_active && (r_div == 8'd0) && r_tck;

    // Preamble TMS pattern (LSB = first TCK) and count of TCKs after the first.
    always_comb begin
        w_pat      = RESET_PAT;
        w_pre_left = 3'd5;
        w_is_scan  = 1'b0;
        case (cmd_type)
            2'd1: begin
                w_pat      = 6'b000011;
                w_pre_left = 3'd3;
                w_is_scan  = 1'b1;
            end
            2'd2: begin
                w_pat      = 6'b000001;
                w_pre_left = 3'd2;
                w_is_scan  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= S_RESET_SEQ;
            r_div       <= DIV_RELOAD;
            r_tck       <= 1'b0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_is_scan   <= 1'b0;
            r_len       <= '0;
            r_shift_cnt <= '0;
            r_data      <= '0;
            r_cap       <= '0;
            r_pat       <= RESET_PAT;
            r_pre_left  <= 3'd5;
            r_post_last <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;

            // Phase engine: D clocks low, then D clocks high; TDO taken at the rise.
            if (w_active) begin
                if (r_div != 8'd0) begin
                    r_div <= r_div - 8'd1;
                end else begin
                    r_div <= DIV_RELOAD;
                    r_tck <= ~r_tck;
                    if (!r_tck && r_state == S_SHIFT)
                        r_cap <= {jtag_tdo, r_cap[31:1]};
                end
            end

            case (r_state)
                S_RESET_SEQ, S_PREAMBLE: begin
                    if (w_fall) begin
                        if (r_pre_left != 3'd0) begin
                            r_pre_left <= r_pre_left - 3'd1;
                            r_pat      <= r_pat >> 1;
                            r_tms      <= r_pat[1];
                        end else if (r_state == S_RESET_SEQ) begin
                            r_state     <= S_IDLE;
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else if (!r_is_scan) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                            r_tms   <= (r_shift_cnt == 5'd0);
                            r_tdi   <= r_data[0];
                        end
                    end
                end

                S_SHIFT: begin
                    if (w_fall) begin
                        if (r_shift_cnt == 5'd0) begin
                            r_state     <= S_POSTAMBLE;
                            r_tms       <= 1'b1;
                            r_tdi       <= 1'b0;
                            r_post_last <= 1'b0;
                        end else begin
                            r_shift_cnt <= r_shift_cnt - 5'd1;
                            r_tms       <= (r_shift_cnt == 5'd1);
                            r_tdi       <= r_data[1];
                            r_data      <= r_data >> 1;
                        end
                    end
                end

                S_POSTAMBLE: begin
                    if (w_fall) begin
                        if (!r_post_last) begin
                            r_post_last <= 1'b1;
                            r_tms       <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Captured bits entered at the top; right-align them to bit 0.
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= r_is_scan ? (r_cap >> (5'd31 - r_len)) : 32'd0;
                    r_state     <= S_IDLE;
                end

                S_IDLE: begin
                    if (!r_cmd_ready) begin
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_PREAMBLE;
                        r_is_scan   <= w_is_scan;
                        r_len       <= cmd_length;
                        r_shift_cnt <= cmd_length;
                        r_data      <= cmd_data;
                        r_cap       <= '0;
                        r_pat       <= w_pat;
                        r_pre_left  <= w_pre_left;
                        r_tms       <= w_pat[0];
                        r_tdi       <= 1'b0;
                        r_tck       <= 1'b0;
                        r_div       <= DIV_RELOAD;
                    end
                end

                default: r_state <= S_RESET_SEQ;
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign jtag_tck  = r_tck;
    assign jtag_tms  = r_tms;
    assign jtag_tdi  = r_tdi;

endmodule

// File: tb/tb_jtag_host_controller.sv
// Bench for jtag_host_controller: a behavioural 1149.1 TAP target plus a
// scoreboard of expected responses checked by an independent monitor.
module tb_jtag_host_controller;

    localparam int DIV = 2;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = '0;
    logic [4:0]  cmd_length = '0;
    logic [31:0] cmd_data = '0;
    logic        cmd_ready, rsp_valid, jtag_tck, jtag_tms, jtag_tdi, jtag_tdo, busy;
    logic [31:0] rsp_data;

    jtag_host_controller #(.CLOCK_DIVIDER(DIV)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_length(cmd_length), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
        .jtag_tdo(jtag_tdo), .busy(busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural TAP target ----------------
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    typedef bit bitq_t[$];

    tap_t        tap = SHDR;
    logic [31:0] dr_cap = '0, ir_cap = '0, sh = '0, dr_in = '0, ir_in = '0;
    int          sh_n = 0, dr_n = 0, ir_n = 0;
    bit          tdi_bad = 0;
    bitq_t       tms_q;

    assign jtag_tdo = (tap == SHDR || tap == SHIR) ? sh[0] : 1'b0;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            UPIR:  return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge jtag_tck) begin
        tms_q.push_back(jtag_tms);
        if (!(tap == SHDR || tap == SHIR) && jtag_tdi !== 1'b0) tdi_bad = 1;
        case (tap)
            CAPDR: begin sh = dr_cap; sh_n = 0; end
            CAPIR: begin sh = ir_cap; sh_n = 0; end
            SHDR, SHIR: begin sh = {jtag_tdi, sh[31:1]}; sh_n++; end
            UPDR: begin dr_in = (sh_n == 0) ? 32'd0 : sh >> (32 - sh_n); dr_n = sh_n; end
            UPIR: begin ir_in = (sh_n == 0) ? 32'd0 : sh >> (32 - sh_n); ir_n = sh_n; end
            default: ;
        endcase
        tap = tap_next(tap, jtag_tms);
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          typ;   // 0 reset, 1 IR, 2 DR
        int          n;     // bits shifted
        logic [31:0] data;
        logic [31:0] rsp;
        int          acc;   // cycle of the accept edge
    } exp_t;

    exp_t sb[$];
    int   last_rsp_cyc = -100;

    function automatic logic [31:0] mask_of(int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    function automatic bitq_t exp_tms(int typ, int n);
        bitq_t q;
        if (typ == 0) begin
            q = '{1, 1, 1, 1, 1, 0};
        end else begin
            if (typ == 1) q = '{1, 1, 0, 0};
            else          q = '{1, 0, 0};
            for (int i = 0; i < n; i++) q.push_back(i == n - 1);
            q.push_back(1);
            q.push_back(0);
        end
        return q;
    endfunction

    function automatic int n_tck(int typ, int n);
        return (typ == 0) ? 6 : (typ == 1) ? n + 6 : n + 5;
    endfunction

    task automatic cmp_tms(input string name, input int typ, input int n);
        bitq_t eq;
        int    bad;
        eq = exp_tms(typ, n);
        bad = 0;
        chk({name, "_count"}, tms_q.size(), eq.size());
        for (int i = 0; i < eq.size() && i < tms_q.size(); i++)
            if (tms_q[i] != eq[i]) bad++;
        chk(name, bad, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge wb_clk_i);
            if (rsp_valid === 1'b1) begin
                last_rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("rsp  typ=%0d n=%0d data=%08h rsp=%08h exp=%08h",
                             e.typ, e.n, e.data, rsp_data, e.rsp);
                    chk("rsp_data", rsp_data, e.rsp);
                    chk("rsp_latency", cyc, e.acc + 2 * DIV * n_tck(e.typ, e.n) + 1);
                    chk("tck_low_at_rsp", jtag_tck, 0);
                    chk("ready_low_at_rsp", cmd_ready, 0);
                    cmp_tms("tms_seq", e.typ, e.n);
                    chk("tdi_outside_shift", tdi_bad, 0);
                    chk("tap_in_rti", (tap == RTI), 1);
                    if (e.typ == 2) begin
                        chk("target_dr", dr_in, e.data & mask_of(e.n));
                        chk("target_dr_len", dr_n, e.n);
                    end else if (e.typ == 1) begin
                        chk("target_ir", ir_in, e.data & mask_of(e.n));
                        chk("target_ir_len", ir_n, e.n);
                    end
                    @(negedge wb_clk_i);
                    chk("rsp_pulse_width", rsp_valid, 0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready(input string name);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (cmd_ready !== 1'b1) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic send(input int typ, input int len, input logic [31:0] data,
                        input logic [31:0] cap, input bit hold, output int acc);
        exp_t e;
        acc = -1;
        wait_ready("send_ready");
        if (cmd_ready === 1'b1) begin
            dr_cap = cap;
            ir_cap = cap;
            cmd_valid  = 1'b1;
            cmd_type   = 2'(typ);
            cmd_length = 5'(len);
            cmd_data   = data;
            e.typ  = (typ == 1 || typ == 2) ? typ : 0;
            e.n    = len + 1;
            e.data = data;
            e.rsp  = (e.typ == 0) ? 32'd0 : (cap & mask_of(e.n));
            e.acc  = cyc + 1;
            acc    = e.acc;
            sb.push_back(e);
            tms_q.delete();
            tdi_bad = 0;
            $display("cmd  typ=%0d len=%0d data=%08h cap=%08h", typ, len, data, cap);
            @(negedge wb_clk_i);
            if (!hold) cmd_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tck"}, jtag_tck, 0);
        chk({tag, "_tms"}, jtag_tms, 1);
        chk({tag, "_tdi"}, jtag_tdi, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
    endtask

    task automatic release_and_check(input string tag);
        int r0;
        r0 = cyc;
        wb_rst_i = 1'b0;
        tms_q.delete();
        tdi_bad = 0;
        @(negedge wb_clk_i);
        wait_ready(tag);
        $display("tap reset done at cycle %0d (reset released after %0d)", cyc, r0);
        chk({tag, "_ready_cycle"}, cyc, r0 + 12 * DIV);
        chk({tag, "_busy_low"}, busy, 0);
        cmp_tms({tag, "_tms"}, 0, 0);
        chk({tag, "_tap_rti"}, (tap == RTI), 1);
    endtask

    initial begin
        int acc;
        int n;
        logic [31:0] cap;
        // A command offered during reset must be ignored.
        cmd_valid = 1'b1;
        cmd_type  = 2'd2;
        cmd_data  = 32'hFFFF_FFFF;
        repeat (3) @(negedge wb_clk_i);
        check_reset_outputs("reset");
        chk("reset_rsp_data", rsp_data, 0);
        cmd_valid = 1'b0;
        release_and_check("powerup");

        send(1, 4, 32'h0000_0001, 32'h0000_0001, 0, acc);
        send(2, 31, 32'hDEAD_BEEF, 32'h1234_5678, 0, acc);
        send(2, 0, 32'h0000_0000, 32'hFFFF_FFFF, 0, acc);
        send(0, 9, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 0, acc);
        send(3, 17, 32'h0F0F_0F0F, 32'h3333_3333, 0, acc);

        // cmd_valid held through a scan while cmd_data changes.
        cap = $urandom;
        send(2, 7, 32'h0000_00C3, cap, 1, acc);
        cmd_data = 32'h0000_003C;
        send(2, 7, 32'h0000_003C, cap, 0, acc);
        chk("accept_after_rsp", acc, last_rsp_cyc + 2);

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
            send(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), $urandom, $urandom, 0, acc);
        end

        // Reset in the middle of a DR shift abandons the command.
        send(2, 31, $urandom, $urandom, 0, acc);
        n = 0;
        while (tap != SHDR && n < 500) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("reached_shift_dr", (tap == SHDR), 1);
        repeat (10) @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        sb.delete();
        @(negedge wb_clk_i);
        check_reset_outputs("midreset");
        release_and_check("midreset");

        send(1, int'($urandom_range(0, 31)), $urandom, $urandom, 0, acc);
        send(2, int'($urandom_range(0, 31)), $urandom, $urandom, 0, acc);

        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (4) @(negedge wb_clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
